// File: rtl/beta_muldiv_unit.sv
// Beta multi-cycle multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one step per clock, with a start/busy/done handshake toward control and writeback.
module beta_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic             dz
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // FIX is the sign-correction/writeback cycle between the last step and DONE.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_div_q;
    logic             neg_q;
    logic             neg_r;
    logic             dz_pend;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;

    logic             is_div_in;
    logic             signed_in;
    logic             div_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        is_div_in = (op == 2'b01) || (op == 2'b10);
        signed_in = (op == 2'b10);
        div_zero  = is_div_in && (B == '0);
        a_mag     = (signed_in && A[WIDTH-1]) ? -A : A;
        b_mag     = (signed_in && B[WIDTH-1]) ? -B : B;
    end

    // hi/lo hold {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        hi_nx   = hi;
        lo_nx   = lo;
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        trial   = {hi, lo[WIDTH-1]} - {1'b0, opnd};
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                hi_nx = trial[WIDTH-1:0];
                lo_nx = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = {hi[WIDTH-2:0], lo[WIDTH-1]};
                lo_nx = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = add_sum[WIDTH:1];
            lo_nx = {add_sum[0], lo[WIDTH-1:1]};
        end
    end

    // NOTE: the datapath registers are few and cheap, so they all take the async reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_pend  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            Y        <= '0;
            R        <= '0;
            dz       <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        is_div_q <= is_div_in;
                        dz_pend  <= div_zero;
                        if (div_zero) begin
                            hi    <= A;
                            lo    <= '1;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= S_FIX;
                        end else begin
                            hi    <= '0;
                            lo    <= is_div_in ? a_mag : B;
                            opnd  <= is_div_in ? b_mag : A;
                            neg_q <= signed_in && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r <= signed_in && A[WIDTH-1];
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    Y     <= neg_q ? -lo : lo;
                    R     <= neg_r ? -hi : hi;
                    dz    <= dz_pend;
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beta_muldiv_unit.sv
// Self-checking bench for beta_muldiv_unit: a behavioural model fills a scoreboard queue
// at launch, and each scenario pops and compares when done is seen.
module tb_beta_muldiv_unit;
    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] y;
    logic [W-1:0] r;

    typedef struct packed {
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         dz;
        logic [7:0]   lat;
    } res_t;

    res_t sb[$];
    res_t last = '0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    beta_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .op    (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .Y     (y),
        .R     (r),
        .dz    (dz)
    );

    function automatic res_t model(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        res_t           m;
        logic [2*W-1:0] p;
        m     = '0;
        m.lat = 8'd33;
        if (o == 2'b01 || o == 2'b10) begin
            if (bb == '0) begin
                m.y = '1; m.r = aa; m.dz = 1'b1; m.lat = 8'd1;
            end else if (o == 2'b01) begin
                m.y = aa / bb; m.r = aa % bb;
            end else if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
                m.y = 32'h8000_0000; m.r = '0;
            end else begin
                m.y = $signed(aa) / $signed(bb);
                m.r = $signed(aa) % $signed(bb);
            end
        end else begin
            p   = {{W{1'b0}}, aa} * {{W{1'b0}}, bb};
            m.y = p[W-1:0];
            m.r = p[2*W-1:W];
        end
        return m;
    endfunction

    // Starts at a falling edge; returns at the falling edge after the sampling edge (edge 0).
    task automatic launch(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        op = o; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts edges since edge 0. lat stays 0 on timeout.
    task automatic collect(input int base, output res_t got);
        int cyc = base;
        got = '0;
        while (cyc < base + 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done === 1'b1) begin
                got.y = y; got.r = r; got.dz = dz; got.lat = 8'(cyc);
                return;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, dz} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctl: busy/done/dz=%b, expected 000", {busy, done, dz});
        end
        n_vec++;
        if (y !== '0 || r !== '0) begin
            n_err++; $display("FAIL reset_data: y=%h r=%h, expected 0 0", y, r);
        end
        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_start: busy=%b, expected 0", busy);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL reset_release: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_mul;
        res_t got, exp;
        logic [1:0]   o;
        logic [W-1:0] aa, bb;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       begin o = 2'b00; aa = 32'hFFFF_FFFF; bb = 32'h2; end
                1:       begin o = 2'b11; aa = 32'd3; bb = 32'd5; end
                2:       begin o = 2'b00; aa = 32'hFFFF_FFFF; bb = 32'hFFFF_FFFF; end
                default: begin o = 2'b00; aa = $urandom; bb = $urandom; end
            endcase
            if (i == 0) sb.push_back(res_t'{y: 32'hFFFF_FFFE, r: 32'h1, dz: 1'b0, lat: 8'd33});
            else if (i == 1) sb.push_back(res_t'{y: 32'd15, r: 32'd0, dz: 1'b0, lat: 8'd33});
            else sb.push_back(model(o, aa, bb));
            launch(o, aa, bb);
            collect(0, got);
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL mul[%0d]: got y=%h r=%h dz=%b lat=%0d, expected y=%h r=%h dz=%b lat=%0d",
                         i, got.y, got.r, got.dz, got.lat, exp.y, exp.r, exp.dz, exp.lat);
            end
            last = exp;
            @(negedge clk);
        end
    endtask

    task automatic test_div;
        res_t got, exp;
        logic [1:0]   o;
        logic [W-1:0] aa, bb;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin o = 2'b10; aa = -32'sd7;  bb = 32'd2; end
                1: begin o = 2'b01; aa = 32'd100;  bb = 32'd7; end
                2: begin o = 2'b10; aa = 32'd7;    bb = -32'sd2; end
                3: begin o = 2'b10; aa = -32'sd100; bb = -32'sd9; end
                4: begin o = 2'b01; aa = 32'd5;    bb = 32'd9; end
                5: begin o = 2'b01; aa = 32'hFFFF_FFFF; bb = 32'd1; end
                default: begin
                    o = (i == 6) ? 2'b01 : 2'b10; aa = $urandom; bb = $urandom_range(1, 50000);
                    if (i == 7) bb = -bb;
                end
            endcase
            if (i == 0) sb.push_back(res_t'{y: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0, lat: 8'd33});
            else if (i == 1) sb.push_back(res_t'{y: 32'd14, r: 32'd2, dz: 1'b0, lat: 8'd33});
            else sb.push_back(model(o, aa, bb));
            launch(o, aa, bb);
            collect(0, got);
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL div[%0d]: got y=%h r=%h dz=%b lat=%0d, expected y=%h r=%h dz=%b lat=%0d",
                         i, got.y, got.r, got.dz, got.lat, exp.y, exp.r, exp.dz, exp.lat);
            end
            last = exp;
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero;
        res_t got, exp;
        logic [1:0]   o;
        logic [W-1:0] aa, bb;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin o = 2'b01; aa = 32'd5; bb = 32'd0; end
                1:       begin o = 2'b00; aa = 32'd3; bb = 32'd4; end
                default: begin o = 2'b10; aa = 32'h8000_0000; bb = 32'd0; end
            endcase
            if (i == 0) sb.push_back(res_t'{y: 32'hFFFF_FFFF, r: 32'd5, dz: 1'b1, lat: 8'd1});
            else if (i == 1) sb.push_back(res_t'{y: 32'd12, r: 32'd0, dz: 1'b0, lat: 8'd33});
            else sb.push_back(model(o, aa, bb));
            launch(o, aa, bb);
            collect(0, got);
            exp = sb.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL divzero[%0d]: got y=%h r=%h dz=%b lat=%0d, expected y=%h r=%h dz=%b lat=%0d",
                         i, got.y, got.r, got.dz, got.lat, exp.y, exp.r, exp.dz, exp.lat);
            end
            last = exp;
            repeat (3) @(negedge clk);
            n_vec++;
            if (y !== last.y || r !== last.r || dz !== last.dz || busy !== 1'b0) begin
                n_err++;
                $display("FAIL divzero_hold[%0d]: y=%h r=%h dz=%b busy=%b, expected y=%h r=%h dz=%b busy=0",
                         i, y, r, dz, busy, last.y, last.r, last.dz);
            end
        end
    endtask

    task automatic test_overflow;
        res_t got, exp;
        sb.push_back(res_t'{y: 32'h8000_0000, r: 32'd0, dz: 1'b0, lat: 8'd33});
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        collect(0, got);
        exp = sb.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL divs_ovf: got y=%h r=%h dz=%b lat=%0d, expected y=%h r=%h dz=%b lat=%0d",
                     got.y, got.r, got.dz, got.lat, exp.y, exp.r, exp.dz, exp.lat);
        end
        last = exp;
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        res_t got, exp;
        sb.push_back(model(2'b00, 32'd6, 32'd7));
        launch(2'b00, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        op = 2'b01; a = 32'd50; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(6, got);
        exp = sb.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL start_in_run: got y=%h r=%h dz=%b lat=%0d, expected y=%h r=%h dz=%b lat=%0d",
                     got.y, got.r, got.dz, got.lat, exp.y, exp.r, exp.dz, exp.lat);
        end
        last = exp;
        op = 2'b01; a = 32'd50; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== last.y || dz !== last.dz) begin
            n_err++;
            $display("FAIL start_in_done: busy=%b done=%b y=%h dz=%b, expected busy=0 done=0 y=%h dz=%b",
                     busy, done, y, dz, last.y, last.dz);
        end
        @(negedge clk);
    endtask

    task automatic test_flush;
        int seen;
        launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== last.y || r !== last.r || dz !== last.dz) begin
            n_err++;
            $display("FAIL flush_run: busy=%b done=%b y=%h r=%h dz=%b, expected busy=0 done=0 y=%h r=%h dz=%b",
                     busy, done, y, r, dz, last.y, last.r, last.dz);
        end
        op = 2'b01; a = 32'd9; b = 32'd0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL flush_start: busy=%b, expected 0", busy);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0 || y !== last.y || r !== last.r || dz !== last.dz) begin
            n_err++;
            $display("FAIL flush_quiet: %0d active cycles y=%h r=%h, expected 0 cycles y=%h r=%h",
                     seen, y, r, last.y, last.r);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        launch(2'b01, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, dz} !== 3'b000 || y !== '0 || r !== '0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b dz=%b y=%h r=%h, expected all 0", busy, done, dz, y, r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last = '0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++; $display("FAIL reset_mid_quiet: %0d active cycles, expected 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        res_t got, exp;
        sb.push_back(model(2'b00, 32'hDEAD_BEEF, 32'h0000_1001));
        launch(2'b00, 32'hDEAD_BEEF, 32'h0000_1001);
        collect(0, got);
        exp = sb.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL b2b_first: got y=%h r=%h dz=%b lat=%0d, expected y=%h r=%h dz=%b lat=%0d",
                     got.y, got.r, got.dz, got.lat, exp.y, exp.r, exp.dz, exp.lat);
        end
        last = exp;
        // Raised in the DONE cycle and held: only the following cycle may accept it.
        op = 2'b10; a = -32'sd12345; b = 32'd77; start = 1'b1;
        @(negedge clk);
        sb.push_back(model(2'b10, -32'sd12345, 32'd77));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || y !== last.y || r !== last.r) begin
            n_err++;
            $display("FAIL b2b_hold: busy=%b y=%h r=%h, expected busy=1 y=%h r=%h", busy, y, r, last.y, last.r);
        end
        collect(0, got);
        exp = sb.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL b2b_second: got y=%h r=%h dz=%b lat=%0d, expected y=%h r=%h dz=%b lat=%0d",
                     got.y, got.r, got.dz, got.lat, exp.y, exp.r, exp.dz, exp.lat);
        end
        last = exp;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_div_zero;
        test_overflow;
        test_start_ignored;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
